regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 47 ++++
 rtl/regfile_writeback.sv | 117 +++++++++++
 tb/tb_regfile_writeback.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Writeback bundle between the execute/load pipes, decode and the
// register-file write port.
//   alu_*  : ALU result (no back-pressure)
//   ld_*   : load-return handshake (ld_valid/ld_ready)
//   iss_*  : load issue notification for the pending scoreboard
//   rs*    : decode source registers, stall back to decode
//   rd_*   : registered register-file write port
// slave  : the writeback block; master : the pipeline driving it.
interface regfile_writeback_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  alu_valid;
    logic [4:0]            alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  ld_valid;
    logic [4:0]            ld_rd;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  iss_load;
    logic [4:0]            iss_rd;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic                  stall;
    logic                  rd_we;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  iss_load, iss_rd,
        input  rs1_addr, rs2_addr,
        output stall,
        output rd_we, rd_addr, rd_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output iss_load, iss_rd,
        output rs1_addr, rs2_addr,
        input  stall,
        input  rd_we, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter with load-return queue and pending
// scoreboard.
//   clk, rst_n : clock, async active-low reset
//   bus        : regfile_writeback_if.slave (see interface for signals)
// ALU results always win the write port; load returns are queued in an
// in-order FIFO and drained in cycles without an ALU result. A pending
// bit per register tracks loads in flight so decode can stall.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_writeback_if.slave  bus
);
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]            r_fifo_rd   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [LQ_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [31:0]           r_pending;
    logic                  r_rd_we;
    logic [4:0]            r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_ld_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [4:0]            w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [31:0]           w_pending_nxt;
    logic                  w_stall1;
    logic                  w_stall2;

    assign w_ld_ready  = (r_count != CNT_W'(LQ_DEPTH));
    assign w_push      = bus.ld_valid && w_ld_ready;
    // Queue is never bypassed: only entries already stored can be popped.
    assign w_pop       = !bus.alu_valid && (r_count != '0);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Storage needs no reset; validity is carried by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.ld_rd;
            r_fifo_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writes to x0 still pass through the port registers but never enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if (bus.alu_valid) begin
            r_rd_we   <= (bus.alu_rd != 5'd0);
            r_rd_addr <= bus.alu_rd;
            r_rd_data <= bus.alu_data;
        end else if (w_pop) begin
            r_rd_we   <= (w_head_rd != 5'd0);
            r_rd_addr <= w_head_rd;
            r_rd_data <= w_head_data;
        end else begin
            r_rd_we   <= 1'b0;
        end
    end

    // Clear applied first so a same-cycle issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop && (w_head_rd != 5'd0))
            w_pending_nxt[w_head_rd] = 1'b0;
        if (bus.iss_load && (bus.iss_rd != 5'd0))
            w_pending_nxt[bus.iss_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pending_nxt;
    end

    // The write-port term covers a register file that returns old data
    // when read on the same edge it is written.
    always_comb begin
        w_stall1 = (bus.rs1_addr != 5'd0) &&
                   (r_pending[bus.rs1_addr] || (r_rd_we && (r_rd_addr == bus.rs1_addr)));
        w_stall2 = (bus.rs2_addr != 5'd0) &&
                   (r_pending[bus.rs2_addr] || (r_rd_we && (r_rd_addr == bus.rs2_addr)));
    end

    assign bus.ld_ready = w_ld_ready;
    assign bus.stall    = w_stall1 || w_stall2;
    assign bus.rd_we    = r_rd_we;
    assign bus.rd_addr  = r_rd_addr;
    assign bus.rd_data  = r_rd_data;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    logic clk;
    logic rst_n;

    regfile_writeback_if #(.DATA_WIDTH(32)) bus ();

    regfile_writeback #(.DATA_WIDTH(32), .LQ_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endfunction

    // Monitor: every write presented on the port must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.rd_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected none",
                         bus.rd_addr, bus.rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(bus.rd_addr), 32'(e.a));
                chk("wb_data", bus.rd_data, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
        bus.iss_load  = 0; bus.iss_rd = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_we",    32'(bus.rd_we),    32'd0);
        chk("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
        chk("rst_rd_data",  bus.rd_data,       32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_stall",    32'(bus.stall),    32'd0);
        rst_n = 1'b1;
        bus.rs1_addr = 0;
        bus.rs2_addr = 0;
        tick();

        // ALU only
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        tick();
        idle_inputs();
        chk("alu_we", 32'(bus.rd_we), 32'd1);
        tick();
        chk("alu_we_drop", 32'(bus.rd_we), 32'd0);

        // Contention: ALU holds the port for 3 cycles while two loads queue
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h100;
        bus.ld_valid  = 1; bus.ld_rd  = 5'd7; bus.ld_data  = 32'h11;
        exp_q.push_back('{5'd3, 32'h100});
        tick();
        bus.alu_data = 32'h101;
        bus.ld_rd = 5'd8; bus.ld_data = 32'h22;
        chk("cont_ready_1", 32'(bus.ld_ready), 32'd1);
        exp_q.push_back('{5'd3, 32'h101});
        tick();
        bus.ld_valid = 0;
        bus.alu_data = 32'h102;
        chk("cont_ready_full", 32'(bus.ld_ready), 32'd0);
        exp_q.push_back('{5'd3, 32'h102});
        tick();
        idle_inputs();
        chk("cont_ready_still_full", 32'(bus.ld_ready), 32'd0);
        exp_q.push_back('{5'd7, 32'h11});
        tick();
        chk("cont_ready_after_pop", 32'(bus.ld_ready), 32'd1);
        exp_q.push_back('{5'd8, 32'h22});
        tick();
        tick();
        chk("cont_drained_we", 32'(bus.rd_we), 32'd0);

        // Scoreboard: load to x9 blocks a reader of x9
        bus.iss_load = 1; bus.iss_rd = 5'd9;
        tick();
        idle_inputs();
        bus.rs1_addr = 5'd9;
        #1 chk("sb_stall_pending", 32'(bus.stall), 32'd1);
        tick();
        chk("sb_stall_hold", 32'(bus.stall), 32'd1);
        bus.ld_valid = 1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
        exp_q.push_back('{5'd9, 32'h99});
        tick();
        bus.ld_valid = 0;
        #1 chk("sb_stall_queued", 32'(bus.stall), 32'd1);
        tick();
        chk("sb_write_cycle_we",    32'(bus.rd_we), 32'd1);
        chk("sb_write_cycle_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("sb_stall_released", 32'(bus.stall), 32'd0);
        bus.rs1_addr = 0;

        // x0 handling
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5;
        tick();
        idle_inputs();
        chk("x0_alu_we", 32'(bus.rd_we), 32'd0);
        bus.ld_valid = 1; bus.ld_rd = 5'd0; bus.ld_data = 32'h6;
        tick();
        bus.ld_valid = 0;
        tick();
        chk("x0_ld_we", 32'(bus.rd_we), 32'd0);
        chk("x0_ld_popped_ready", 32'(bus.ld_ready), 32'd1);
        bus.iss_load = 1; bus.iss_rd = 5'd0;
        tick();
        bus.iss_load = 0;
        bus.rs1_addr = 5'd0;
        #1 chk("x0_stall", 32'(bus.stall), 32'd0);

        // Same-cycle set/clear on x4
        bus.iss_load = 1; bus.iss_rd = 5'd4;
        tick();
        bus.iss_load = 0;
        bus.ld_valid = 1; bus.ld_rd = 5'd4; bus.ld_data = 32'h44;
        exp_q.push_back('{5'd4, 32'h44});
        tick();
        bus.ld_valid = 0;
        bus.iss_load = 1; bus.iss_rd = 5'd4;
        tick();
        bus.iss_load = 0;
        bus.rs2_addr = 5'd4;
        #1 chk("setclr_stall_write", 32'(bus.stall), 32'd1);
        tick();
        chk("setclr_stall_persist", 32'(bus.stall), 32'd1);
        bus.rs2_addr = 0;

        // Reset mid-operation with two queued loads and pending x6
        bus.iss_load = 1; bus.iss_rd = 5'd6;
        bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
        bus.ld_valid = 1; bus.ld_rd = 5'd10; bus.ld_data = 32'hAA;
        exp_q.push_back('{5'd1, 32'hA1});
        tick();
        bus.iss_load = 0;
        bus.alu_data = 32'hA2;
        bus.ld_rd = 5'd11; bus.ld_data = 32'hBB;
        exp_q.push_back('{5'd1, 32'hA2});
        tick();
        idle_inputs();
        bus.rs1_addr = 5'd6;
        #1;
        chk("rmid_full",  32'(bus.ld_ready), 32'd0);
        chk("rmid_stall", 32'(bus.stall),    32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_we",    32'(bus.rd_we),    32'd0);
        chk("rmid_ready", 32'(bus.ld_ready), 32'd1);
        chk("rmid_stall_cleared", 32'(bus.stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_stall", 32'(bus.stall),    32'd0);
        chk("post_rst_ready", 32'(bus.ld_ready), 32'd1);
        chk("post_rst_we",    32'(bus.rd_we),    32'd0);

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
